// File: rtl/lscc_board_pkg.sv
// rtl/lscc_board_pkg.sv - shared button-input types and prescaler helper
package lscc_board_pkg;

    typedef enum logic [1:0] {
        REL    = 2'd0,
        P_WAIT = 2'd1,
        PRS    = 2'd2,
        R_WAIT = 2'd3
    } btn_state_e;

    function automatic int ms_terminal(input int clk_in_mhz);
        return clk_in_mhz * 1000 - 1;
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// rtl/btn_debounce_cell.sv - one-button debounce FSM; long-press timer under `BTN_LONGPRESS_EN
module btn_debounce_cell
    import lscc_board_pkg::*;
#(
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic smp,
    input  logic tick_ms,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DCW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEBOUNCE_MS - 1);
    localparam logic [DCW-1:0] DCNT_MAX  = DCW'(DEBOUNCE_MS);

    btn_state_e     state_q, state_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [DCW-1:0] dcnt_inc;
    logic           dcnt_done;
    logic           press_q, press_d;
    logic           release_q, release_d;

    // Commit lands on the tick that brings dcnt to DEBOUNCE_MS.
    assign dcnt_done = tick_ms && (dcnt_q == DCNT_LAST);
    assign dcnt_inc  = (dcnt_q == DCNT_MAX) ? dcnt_q : dcnt_q + DCW'(1);

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            REL: begin
                if (smp) begin
                    state_d = P_WAIT;
                    dcnt_d  = '0;
                end
            end
            P_WAIT: begin
                if (!smp) begin
                    state_d = REL;
                end else if (tick_ms) begin
                    dcnt_d = dcnt_inc;
                    if (dcnt_done) begin
                        state_d = PRS;
                        press_d = 1'b1;
                    end
                end
            end
            PRS: begin
                if (!smp) begin
                    state_d = R_WAIT;
                    dcnt_d  = '0;
                end
            end
            R_WAIT: begin
                if (smp) begin
                    state_d = PRS;
                end else if (tick_ms) begin
                    dcnt_d = dcnt_inc;
                    if (dcnt_done) begin
                        state_d   = REL;
                        release_d = 1'b1;
                    end
                end
            end
            default: state_d = REL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REL;
            dcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level         = (state_q == PRS) || (state_q == R_WAIT);
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BTN_LONGPRESS_EN
    localparam int HCW = $clog2(LONG_PRESS_MS + 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(LONG_PRESS_MS);

    logic [HCW-1:0] hold_q;
    logic           long_q;

    // Hold time runs across R_WAIT bounces; it is zero whenever the button is not committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!level) begin
                hold_q <= '0;
            end else if (tick_ms && (hold_q != HOLD_MAX)) begin
                hold_q <= hold_q + HCW'(1);
                long_q <= (hold_q == HOLD_MAX - HCW'(1));
            end
        end
    end

    assign long_pulse = long_q;
`else
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_PRESS_MS > DEBOUNCE_MS);
    assign long_pulse      = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, 1 ms prescaler and per-button debounce; `BTN_LONGPRESS_EN adds long-press
module btn_debounce
    import lscc_board_pkg::*;
#(
    parameter int   NUM_BTN       = 4,
    parameter int   CLK_IN_MHZ    = 125,
    parameter logic BTN_POLARITY  = 1'b0,
    parameter int   DEBOUNCE_MS   = 10,
    parameter int   LONG_PRESS_MS = 1000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o,
    output logic [NUM_BTN-1:0] btn_long_o
);

    localparam int TERM = ms_terminal(CLK_IN_MHZ);
    localparam int PW   = (TERM > 0) ? $clog2(TERM + 1) : 1;
    localparam logic [PW-1:0]      PRESC_TERM = PW'(TERM);
    localparam logic [NUM_BTN-1:0] RELEASED   = {NUM_BTN{~BTN_POLARITY}};

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] smp;
    logic [PW-1:0]      presc_q;
    logic               tick_ms;

    // Sync flops reset to the released pin level so reset never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    assign smp = sync2_q ^ RELEASED;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else if (tick_ms) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign tick_ms = (presc_q == PRESC_TERM);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce_cell #(
            .DEBOUNCE_MS   (DEBOUNCE_MS),
            .LONG_PRESS_MS (LONG_PRESS_MS)
        ) u_cell (
            .clk           (clk_i),
            .rst           (rst_i),
            .smp           (smp[i]),
            .tick_ms       (tick_ms),
            .level         (btn_level_o[i]),
            .press_pulse   (btn_press_o[i]),
            .release_pulse (btn_release_o[i]),
            .long_pulse    (btn_long_o[i])
        );
    end

endmodule
